// File: rtl/pipeline_pkg.sv
// Shared encodings for the RV32I pipeline hazard/sequencing logic.
package pipeline_pkg;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_W     = 2'b01;
  localparam logic [1:0] FWD_M     = 2'b10;

  localparam logic [1:0] WDSRC_ALU = 2'b00;
  localparam logic [1:0] WDSRC_MEM = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR
  } mem_state_t;

endpackage

// File: rtl/forward_sel.sv
// Execute-stage operand forwarding select for one source register.
module forward_sel
  import pipeline_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_m_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_w_i,
  output logic [1:0] fwd_o
);

  // Memory stage holds the younger result, so it wins over Writeback.
  always_comb begin
    fwd_o = FWD_NONE;
    if (reg_write_m_i && (rd_m_i != 5'd0) && (rs_i == rd_m_i)) begin
      fwd_o = FWD_M;
    end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rs_i == rd_w_i)) begin
      fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward control and data-memory handshake for the five-stage pipeline.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic [4:0]  rs1_E,
  input  logic [4:0]  rs2_E,
  input  logic [4:0]  rd_E,
  input  logic [1:0]  wdSrc_E,
  input  logic        pcSrc_E,
  input  logic [4:0]  rd_M,
  input  logic        regWrite_M,
  input  logic [1:0]  wdSrc_M,
  input  logic        memWrite_M,
  input  logic [4:0]  rd_W,
  input  logic        regWrite_W,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        stall_F,
  output logic        stall_D,
  output logic        stall_E,
  output logic        stall_M,
  output logic        flush_D,
  output logic        flush_E,
  output logic        flush_W,
  output logic [1:0]  forwardA_E,
  output logic [1:0]  forwardB_E,
  output logic        bus_error,
  output logic [31:0] stall_cycles
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  mem_state_t  state_q, state_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] stall_cnt_q;
  logic        mem_acc_M;
  logic        lu;
  logic        freeze;

  forward_sel u_fwd_a (
    .rs_i          (rs1_E),
    .rd_m_i        (rd_M),
    .reg_write_m_i (regWrite_M),
    .rd_w_i        (rd_W),
    .reg_write_w_i (regWrite_W),
    .fwd_o         (forwardA_E)
  );

  forward_sel u_fwd_b (
    .rs_i          (rs2_E),
    .rd_m_i        (rd_M),
    .reg_write_m_i (regWrite_M),
    .rd_w_i        (rd_W),
    .reg_write_w_i (regWrite_W),
    .fwd_o         (forwardB_E)
  );

  assign mem_acc_M = memWrite_M | (wdSrc_M == WDSRC_MEM);
  assign lu        = (wdSrc_E == WDSRC_MEM) && (rd_E != 5'd0) &&
                     ((rd_E == rs1_D) || (rd_E == rs2_D));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  // The first request cycle is spent in IDLE, so a ready there costs no freeze.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    dmem_req = 1'b0;
    freeze   = 1'b0;
    case (state_q)
      IDLE: begin
        dmem_req = mem_acc_M;
        if (mem_acc_M && !dmem_ready) begin
          freeze  = 1'b1;
          state_d = WAIT;
          tmo_d   = '0;
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        freeze   = !dmem_ready;
        if (dmem_ready) begin
          state_d = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ERR: begin
        freeze = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    stall_F = freeze | (lu & ~pcSrc_E);
    stall_D = freeze | (lu & ~pcSrc_E);
    stall_E = freeze;
    stall_M = freeze;
    flush_W = freeze;
    flush_D = ~freeze & pcSrc_E;
    flush_E = ~freeze & (pcSrc_E | lu);
  end

  assign bus_error = (state_q == ERR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (stall_F && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, corner sequences, randomized model check.
module tb_pipeline_hazard_ctrl;
  import pipeline_pkg::*;

  localparam int MT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic [1:0]  wdSrc_E, wdSrc_M;
  logic        pcSrc_E, regWrite_M, memWrite_M, regWrite_W, dmem_ready;
  logic        dmem_req, stall_F, stall_D, stall_E, stall_M;
  logic        flush_D, flush_E, flush_W, bus_error;
  logic [1:0]  forwardA_E, forwardB_E;
  logic [31:0] stall_cycles;
  logic [12:0] outs;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .wdSrc_E(wdSrc_E), .pcSrc_E(pcSrc_E),
    .rd_M(rd_M), .regWrite_M(regWrite_M), .wdSrc_M(wdSrc_M), .memWrite_M(memWrite_M),
    .rd_W(rd_W), .regWrite_W(regWrite_W), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
    .stall_M(stall_M), .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
    .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
    .bus_error(bus_error), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  assign outs = {dmem_req, stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
                 flush_W, forwardA_E, forwardB_E, bus_error};

  typedef struct packed {
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E;
    logic [1:0] wdSrc_E;
    logic       pcSrc_E;
    logic [4:0] rd_M;
    logic       regWrite_M;
    logic [4:0] rd_W;
    logic       regWrite_W;
    logic [3:0] e_ctl;   // {stall_F, stall_D, flush_D, flush_E}
    logic [1:0] e_fa, e_fb;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic zero_inputs();
    rs1_D = '0; rs2_D = '0; rs1_E = '0; rs2_E = '0; rd_E = '0;
    wdSrc_E = WDSRC_ALU; pcSrc_E = 1'b0;
    rd_M = '0; regWrite_M = 1'b0; wdSrc_M = WDSRC_ALU; memWrite_M = 1'b0;
    rd_W = '0; regWrite_W = 1'b0; dmem_ready = 1'b0;
  endtask

  // Leaves time at posedge+1 with reset released.
  task automatic do_reset();
    zero_inputs();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Reference model state: age = request cycles already spent on the pending access.
  int          age;
  bit          err;
  logic [31:0] mcnt;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic [4:0] rdm,
                                          input logic rwm, input logic [4:0] rdw,
                                          input logic rww);
    if (rwm && rdm != 0 && rs == rdm) return FWD_M;
    if (rww && rdw != 0 && rs == rdw) return FWD_W;
    return FWD_NONE;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, WDSRC_ALU, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 4'b0000, FWD_M,    FWD_NONE};
    vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, WDSRC_ALU, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 4'b0000, FWD_W,    FWD_NONE};
    vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, WDSRC_ALU, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 4'b0000, FWD_NONE, FWD_NONE};
    vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd0, WDSRC_ALU, 1'b0, 5'd9, 1'b0, 5'd9, 1'b1, 4'b0000, FWD_NONE, FWD_W};
    vecs[4]  = '{5'd0, 5'd0, 5'd3, 5'd3, 5'd0, WDSRC_ALU, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 4'b0000, FWD_M,    FWD_M};
    vecs[5]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, WDSRC_MEM, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b1101, FWD_NONE, FWD_NONE};
    vecs[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, WDSRC_MEM, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b0000, FWD_NONE, FWD_NONE};
    vecs[7]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, WDSRC_MEM, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 4'b0011, FWD_NONE, FWD_NONE};
    vecs[8]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, WDSRC_ALU, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b0000, FWD_NONE, FWD_NONE};
    vecs[9]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, WDSRC_MEM, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b1101, FWD_NONE, FWD_NONE};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, WDSRC_ALU, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 4'b0011, FWD_NONE, FWD_NONE};
    vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd0, WDSRC_ALU, 1'b0, 5'd4, 1'b1, 5'd4, 1'b1, 4'b0000, FWD_NONE, FWD_M};

    zero_inputs();
    #2;
    @(negedge clk);
    check("reset_outs", 32'(outs), 32'd0);
    check("reset_stall_cycles", stall_cycles, 32'd0);
    next_cycle();
    reset_n = 1'b1;

    // Combinational vector table with no memory access in flight.
    for (int i = 0; i < 12; i++) begin
      rs1_D = vecs[i].rs1_D; rs2_D = vecs[i].rs2_D; rs1_E = vecs[i].rs1_E;
      rs2_E = vecs[i].rs2_E; rd_E = vecs[i].rd_E; wdSrc_E = vecs[i].wdSrc_E;
      pcSrc_E = vecs[i].pcSrc_E; rd_M = vecs[i].rd_M; regWrite_M = vecs[i].regWrite_M;
      rd_W = vecs[i].rd_W; regWrite_W = vecs[i].regWrite_W;
      @(negedge clk);
      check($sformatf("vec%0d_ctl", i), 32'({stall_F, stall_D, flush_D, flush_E}), 32'(vecs[i].e_ctl));
      check($sformatf("vec%0d_fwdA", i), 32'(forwardA_E), 32'(vecs[i].e_fa));
      check($sformatf("vec%0d_fwdB", i), 32'(forwardB_E), 32'(vecs[i].e_fb));
      check($sformatf("vec%0d_quiet", i), 32'({stall_E, stall_M, flush_W, dmem_req}), 32'd0);
      next_cycle();
    end

    // Memory wait: ready low for 3 request cycles, high on the 4th.
    do_reset();
    memWrite_M = 1'b1;
    for (int c = 0; c < 4; c++) begin
      dmem_ready = (c == 3);
      @(negedge clk);
      check($sformatf("memwait_req_c%0d", c), 32'(dmem_req), 32'd1);
      check($sformatf("memwait_freeze_c%0d", c), 32'({stall_F, stall_E, stall_M, flush_W}),
            (c == 3) ? 32'h0 : 32'hF);
      next_cycle();
    end
    memWrite_M = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    check("memwait_idle_outs", 32'(outs), 32'd0);
    check("memwait_stall_cycles", stall_cycles, 32'd3);
    next_cycle();

    // Zero-wait access.
    wdSrc_M = WDSRC_MEM; dmem_ready = 1'b1;
    @(negedge clk);
    check("zerowait_req", 32'(dmem_req), 32'd1);
    check("zerowait_nostall", 32'(stall_F), 32'd0);
    next_cycle();
    wdSrc_M = WDSRC_ALU; dmem_ready = 1'b0;
    @(negedge clk);
    check("zerowait_stall_cycles", stall_cycles, 32'd3);
    next_cycle();

    // Timeout: 1 IDLE cycle + MT WAIT cycles unanswered, then ERR.
    do_reset();
    wdSrc_M = WDSRC_MEM;
    for (int c = 0; c < MT + 1; c++) begin
      @(negedge clk);
      check($sformatf("tmo_wait_c%0d", c), 32'({dmem_req, stall_F, bus_error}), 32'b110);
      next_cycle();
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("tmo_err_c%0d", c), 32'({dmem_req, stall_F, stall_M, flush_W, bus_error}), 32'b01111);
      next_cycle();
    end
    @(negedge clk);
    zero_inputs();
    reset_n = 1'b0;
    #1;
    check("err_async_reset_outs", 32'(outs), 32'd0);
    check("err_async_reset_cnt", stall_cycles, 32'd0);
    next_cycle();
    reset_n = 1'b1;

    // Saturation of the stall counter.
    wdSrc_E = WDSRC_MEM; rd_E = 5'd7; rs1_D = 5'd7;
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    #1;
    check("sat_preload", stall_cycles, 32'hFFFF_FFFE);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("sat_c%0d", c), stall_cycles, 32'hFFFF_FFFF);
    end
    next_cycle();

    // Randomized run against the behavioural model.
    do_reset();
    age = 0; err = 0; mcnt = '0;
    for (int n = 0; n < 3000; n++) begin
      logic mem_acc, e_frz, e_req, e_lu, e_sF;
      logic [12:0] exp_outs;
      rs1_D = 5'($urandom_range(0, 3)); rs2_D = 5'($urandom_range(0, 3));
      rs1_E = 5'($urandom_range(0, 3)); rs2_E = 5'($urandom_range(0, 3));
      rd_E  = 5'($urandom_range(0, 3)); rd_M  = 5'($urandom_range(0, 3));
      rd_W  = 5'($urandom_range(0, 3));
      wdSrc_E = 2'($urandom_range(0, 3)); wdSrc_M = 2'($urandom_range(0, 3));
      pcSrc_E = ($urandom_range(0, 3) == 0);
      regWrite_M = 1'($urandom); regWrite_W = 1'($urandom);
      memWrite_M = ($urandom_range(0, 3) == 0);
      dmem_ready = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      mem_acc = memWrite_M | (wdSrc_M == WDSRC_MEM);
      if (err) begin
        e_req = 1'b0; e_frz = 1'b1;
      end else if (age > 0) begin
        e_req = 1'b1; e_frz = !dmem_ready;
      end else begin
        e_req = mem_acc; e_frz = mem_acc && !dmem_ready;
      end
      e_lu = (wdSrc_E == WDSRC_MEM) && (rd_E != 0) && (rd_E == rs1_D || rd_E == rs2_D);
      e_sF = e_frz || (e_lu && !pcSrc_E);
      exp_outs = {e_req, e_sF, e_sF, e_frz, e_frz,
                  !e_frz && pcSrc_E, !e_frz && (pcSrc_E || e_lu), e_frz,
                  ref_fwd(rs1_E, rd_M, regWrite_M, rd_W, regWrite_W),
                  ref_fwd(rs2_E, rd_M, regWrite_M, rd_W, regWrite_W), err};
      check("rand_outs", 32'(outs), 32'(exp_outs));
      check("rand_stall_cycles", stall_cycles, mcnt);
      if (e_sF && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
      if (!err && (age > 0 || mem_acc)) begin
        if (dmem_ready) age = 0;
        else begin
          age++;
          if (age > MT) err = 1;
        end
      end
      if ($urandom_range(0, 39) == 0) begin
        do_reset();
        age = 0; err = 0; mcnt = '0;
      end else begin
        next_cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage RV32I pipeline. It drives the stall and flush controls of the stage registers, including the `clr` input of the Decode→Execute control register. It also produces the Execute-stage operand forwarding selects and runs the data-memory handshake, which freezes the pipeline while a memory access in the Memory stage is outstanding. It sits beside the datapath and owns no architectural state, except for a stall-cycle counter and a sticky bus-error flag.

## Interface
- `MEM_TIMEOUT`, default 16: maximum number of cycles spent in WAIT before ERR is entered. Legal range is 2..255.
- `clk` in 1: pipeline clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rs1_D`, `rs2_D` in 5 each: source registers of the Decode instruction.
- `rs1_E`, `rs2_E`, `rd_E` in 5 each: source and destination registers of the Execute instruction.
- `wdSrc_E` in 2: writeback source of the Execute instruction. `WDSRC_MEM` means load.
- `pcSrc_E` in 1: branch or jump taken in Execute.
- `rd_M` in 5, `regWrite_M` in 1, `wdSrc_M` in 2, `memWrite_M` in 1: Memory-stage destination and control.
- `rd_W` in 5, `regWrite_W` in 1: Writeback-stage destination and write enable.
- `dmem_ready` in 1: data memory has completed the presented access this cycle.
- `dmem_req` out 1: a data-memory access is presented.
- `stall_F`, `stall_D`, `stall_E`, `stall_M` out 1 each: hold the corresponding stage register.
- `flush_D`, `flush_E`, `flush_W` out 1 each: load a bubble into the corresponding stage register. `flush_E` drives `clr` of the Decode→Execute control register.
- `forwardA_E`, `forwardB_E` out 2 each: ALU operand select, one of `FWD_NONE`, `FWD_W`, `FWD_M`.
- `bus_error` out 1: sticky; data memory timed out.
- `stall_cycles` out 32: count of cycles with `stall_F` high, saturating.

## Operation
- **Memory access.** `mem_acc_M` = `memWrite_M` OR (`wdSrc_M` == `WDSRC_MEM`).
- **Forwarding, per operand.** Evaluated in order; the first match wins:
  - `rs_E` == `rd_M` AND `regWrite_M` AND `rd_M` ≠ 0 → `FWD_M`
  - else `rs_E` == `rd_W` AND `regWrite_W` AND `rd_W` ≠ 0 → `FWD_W`
  - else `FWD_NONE`
  - Forwarding is purely combinational and unaffected by FSM state.
- **Load-use hazard.** `lu` = (`wdSrc_E` == `WDSRC_MEM`) AND `rd_E` ≠ 0 AND (`rd_E` == `rs1_D` OR `rd_E` == `rs2_D`).
- **FSM states:**
  - IDLE:
    - `dmem_req` = `mem_acc_M`.
    - If `mem_acc_M` AND NOT `dmem_ready` → go to WAIT and clear the timeout counter.
    - Otherwise stay in IDLE.
  - WAIT:
    - `dmem_req` = 1. `freeze` = 1, except in the cycle `dmem_ready` is seen.
    - `dmem_ready` → IDLE.
    - Otherwise the counter increments. When it reaches `MEM_TIMEOUT`-1 → ERR.
  - ERR:
    - `freeze` = 1, `bus_error` = 1, `dmem_req` = 0.
    - Stays in ERR until reset.
  - IDLE with `mem_acc_M` AND NOT `dmem_ready` also sets `freeze` = 1 that cycle.
- **Output priority, highest first:**
  1. `freeze`: `stall_F`/`stall_D`/`stall_E`/`stall_M` = 1 and `flush_W` = 1. All other flushes are 0, and `pcSrc_E`/`lu` are ignored because the Execute stage is held.
  2. `pcSrc_E`: `flush_D` = 1 and `flush_E` = 1, no stalls. This applies even when `lu` is high.
  3. `lu`: `stall_F` = 1, `stall_D` = 1, `flush_E` = 1.
  4. Otherwise all stalls and flushes are 0.
- **`stall_cycles`.** Increments each cycle `stall_F` is 1 and holds at 0xFFFF_FFFF.

## Timing
- On reset assertion the block immediately forces state = IDLE, timeout counter = 0, `bus_error` = 0, `stall_cycles` = 0.
- With all inputs 0 after reset, every output is 0.
- Stall, flush, forward and `dmem_req` are combinational from the inputs and the registered state, valid in the same cycle. There is no added latency.
- **Zero-wait memory** (`dmem_ready` high in the first request cycle): no stall cycles.
- **N-cycle memory** (`dmem_ready` high in the Nth request cycle, N ≥ 2): exactly N-1 freeze cycles.
- A `dmem_ready` seen while in WAIT releases the freeze in that same cycle.
- `reset_n` asserted mid-WAIT or in ERR returns the block to IDLE asynchronously, and the pending access is abandoned.
- The ERR transition occurs on the edge after the cycle in which the counter equals `MEM_TIMEOUT`-1.

## Structure
- Package `pipeline_pkg`:
  - `FWD_NONE`=2'b00, `FWD_W`=2'b01, `FWD_M`=2'b10
  - `WDSRC_ALU`=2'b00, `WDSRC_MEM`=2'b01
  - `mem_state_t` enum {IDLE, WAIT, ERR}
- Sub-module `forward_sel`: combinational, instantiated twice, once for rs1_E and once for rs2_E.
- FSM, timeout counter and stall counter live in the top module.

## Test plan
- **Forwarding:** rs1_E=5, rd_M=5, regWrite_M=1, rd_W=5, regWrite_W=1 → `forwardA_E`=`FWD_M`. Then rd_M=0 → `FWD_W`. Then rd_W=0 → `FWD_NONE`.
- **Load-use:** wdSrc_E=`WDSRC_MEM`, rd_E=7, rs2_D=7 → `stall_F`=`stall_D`=`flush_E`=1 for one cycle. With rd_E=0 instead → no stall.
- **Branch over load-use:** same as the load-use case plus pcSrc_E=1 → `flush_D`=`flush_E`=1, `stall_F`=0.
- **Memory wait:** memWrite_M=1, dmem_ready low for 3 cycles then high → `dmem_req`=1 for 4 cycles, freeze for 3 cycles, `stall_cycles`=3, state ends in IDLE.
- **Timeout:** `MEM_TIMEOUT`=4, load in M, dmem_ready never high → ERR entered, `bus_error`=1 with freeze held. Asserting `reset_n`=0 mid-ERR → all outputs 0 and `stall_cycles`=0 immediately.
- **Saturation:** force `stall_cycles` to 0xFFFF_FFFE, stall 3 cycles → reads 0xFFFF_FFFF.
